// File: rtl/rapid_pkg.sv
// rapid_pkg: shared types and opcode encodings for the RAPID execute stage
package rapid_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;
  typedef struct packed {
    logic       alu;
    logic       alu_imm;
    logic       cond_branch;
    logic       uncond_branch;
    logic       load_upper_imm;
    logic       mem;
    logic       muldiv;
    logic [2:0] fcs_opcode;
    logic       iop;
  } control_s;
  typedef enum logic [1:0] {IDLE, MULDIV, DONE} exec_state_t;
  localparam logic [2:0] ALU_ADD_SUB = 3'b000, ALU_SLL = 3'b001, ALU_SLT = 3'b010, ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100, ALU_SRL_SRA = 3'b101, ALU_OR = 3'b110, ALU_AND = 3'b111;
  localparam logic [2:0] BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100, BR_GE = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110, BR_GEU = 3'b111, JMP_JAL = 3'b010, JMP_JALR = 3'b011;
  localparam logic [2:0] MD_MUL = 3'b000, MD_MULH = 3'b001, MD_MULHSU = 3'b010, MD_MULHU = 3'b011;
  localparam logic [2:0] MD_DIV = 3'b100, MD_DIVU = 3'b101, MD_REM = 3'b110, MD_REMU = 3'b111;
endpackage

// File: rtl/exec_unit_if.sv
// exec_unit_if: upstream/downstream handshake and operand bundle of the execute stage
interface exec_unit_if #(parameter int XLEN = 32);
  logic                 i_valid, o_ready, i_ready, o_valid, o_branch, o_busy;
  rapid_pkg::control_s  i_control_signal, o_control_signal;
  logic [XLEN-1:0]      i_rs1, i_rs2, i_imm, i_pc, o_result, o_next_pc;
  modport slave (input i_valid, i_control_signal, i_rs1, i_rs2, i_imm, i_pc, i_ready,
                 output o_ready, o_valid, o_result, o_next_pc, o_branch, o_control_signal, o_busy);
  modport master (output i_valid, i_control_signal, i_rs1, i_rs2, i_imm, i_pc, i_ready,
                  input o_ready, o_valid, o_result, o_next_pc, o_branch, o_control_signal, o_busy);
endinterface

// File: rtl/exec_unit_muldiv.sv
// muldiv_iter: radix-2 shift-add multiplier and restoring divider on operand magnitudes
module muldiv_iter import rapid_pkg::*; #(parameter int XLEN = 32) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  logic [2:0] op_q;
  logic neg_q, rneg_q, dz_q, busy_q, done_q, a_neg, b_neg;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] b_q, hi_q, lo_q, hi_d, lo_d, a_mag, b_mag, quo, rem;
  logic [XLEN:0] sum, sh, diff;
  logic [2*XLEN-1:0] prod;
  assign a_neg = (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a_i[XLEN-1];
  assign b_neg = (op_i inside {MD_MULH, MD_DIV, MD_REM}) & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  // hi:lo is the product accumulator for multiply and remainder:quotient for divide
  assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign sh   = {hi_q, lo_q[XLEN-1]};
  assign diff = sh - {1'b0, b_q};
  assign hi_d = op_q[2] ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
  assign lo_d = op_q[2] ? {lo_q[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
  assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo  = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
  assign rem  = rneg_q ? -hi_q : hi_q;
  assign result_o = op_q[2] ? (op_q[1] ? rem : quo) : (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign busy_o = busy_q;
  assign done_o = done_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= busy_q && cnt_q == CW'(XLEN - 1);
      if (start_i) begin
        op_q   <= op_i;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        dz_q   <= op_i[2] && b_i == '0;
        b_q    <= op_i[2] ? b_mag : a_mag;
        hi_q   <= '0;
        lo_q   <= op_i[2] ? a_mag : b_mag;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        cnt_q  <= cnt_q + CW'(1);
        busy_q <= cnt_q != CW'(XLEN - 1);
      end
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: valid/ready execute stage; single-cycle integer/branch/jump/AGU ops and iterative RV-M
module exec_unit import rapid_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rapid_pkg::RESET_VECTOR)
) (
  input logic        i_clk,
  input logic        i_reset_n,
  exec_unit_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  exec_state_t state_q, state_d;
  control_s c, ctrl_q, ctrl_d;
  logic valid_q, valid_d, branch_q, branch_d, ready, accept, taken, br_c, md_done;
  logic [XLEN-1:0] result_q, result_d, next_pc_q, next_pc_d, rs1, rs2, imm, pc, p2, sra;
  logic [XLEN-1:0] alu_res, pc4, pc_imm, rs1_imm, res_c, npc_c, md_res;
  logic [SW-1:0] shamt;
  assign c       = bus.i_control_signal;
  assign rs1     = bus.i_rs1;
  assign rs2     = bus.i_rs2;
  assign imm     = bus.i_imm;
  assign pc      = bus.i_pc;
  assign p2      = c.alu_imm ? imm : rs2;
  assign shamt   = p2[SW-1:0];
  assign sra     = $signed(rs1) >>> shamt;
  assign pc4     = pc + XLEN'(4);
  assign pc_imm  = pc + imm;
  assign rs1_imm = rs1 + imm;
  always_comb begin
    case (c.fcs_opcode)
      ALU_ADD_SUB: alu_res = c.iop ? rs1 - p2 : rs1 + p2;
      ALU_SLL:     alu_res = rs1 << shamt;
      ALU_SLT:     alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(p2)};
      ALU_SLTU:    alu_res = {{(XLEN-1){1'b0}}, rs1 < p2};
      ALU_XOR:     alu_res = rs1 ^ p2;
      ALU_SRL_SRA: alu_res = c.iop ? sra : rs1 >> shamt;
      ALU_OR:      alu_res = rs1 | p2;
      default:     alu_res = rs1 & p2;
    endcase
  end
  // fcs[2] selects the ordered compares, fcs[1] unsigned, fcs[0] inverts the sense
  assign taken = c.fcs_opcode[2] ? ((c.fcs_opcode[1] ? rs1 < rs2 : $signed(rs1) < $signed(rs2)) ^ c.fcs_opcode[0])
                                 : ((rs1 == rs2) ^ c.fcs_opcode[0]);
  assign br_c  = c.uncond_branch | (c.cond_branch & taken);
  assign res_c = c.cond_branch ? '0 : c.uncond_branch ? pc4 : c.load_upper_imm ? (c.iop ? imm : pc_imm)
               : c.mem ? rs1_imm : alu_res;
  assign npc_c = c.cond_branch ? (taken ? pc_imm : pc4)
               : c.uncond_branch ? (c.fcs_opcode == JMP_JALR ? {rs1_imm[XLEN-1:1], 1'b0} : pc_imm) : pc4;
  assign ready  = state_q == IDLE || (state_q == DONE && bus.i_ready);
  assign accept = bus.i_valid && ready;
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .start_i  (accept && c.muldiv),
    .op_i     (c.fcs_opcode),
    .a_i      (rs1),
    .b_i      (rs2),
    .busy_o   (bus.o_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    branch_d  = branch_q;
    result_d  = result_q;
    next_pc_d = next_pc_q;
    ctrl_d    = ctrl_q;
    if (state_q == DONE && bus.i_ready) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      branch_d = 1'b0;
    end
    if (state_q == MULDIV && md_done) begin
      state_d  = DONE;
      valid_d  = 1'b1;
      result_d = md_res;
    end
    if (accept) begin
      state_d   = c.muldiv ? MULDIV : DONE;
      valid_d   = !c.muldiv;
      branch_d  = br_c;
      result_d  = res_c;
      next_pc_d = npc_c;
      ctrl_d    = c;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      branch_q  <= 1'b0;
      result_q  <= '0;
      next_pc_q <= RESET_VECTOR;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      branch_q  <= branch_d;
      result_q  <= result_d;
      next_pc_q <= next_pc_d;
      ctrl_q    <= ctrl_d;
    end
  end
  assign bus.o_ready          = ready;
  assign bus.o_valid          = valid_q;
  assign bus.o_branch         = branch_q;
  assign bus.o_result         = result_q;
  assign bus.o_next_pc        = next_pc_q;
  assign bus.o_control_signal = ctrl_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit; expected results come from a behavioural reference model
module tb_exec_unit;
  import rapid_pkg::*;
  parameter int XLEN = 32;
  localparam int C_ALU = 0, C_BR = 1, C_JMP = 2, C_LUI = 3, C_MEM = 4, C_MD = 5;
  typedef struct {
    logic [XLEN-1:0] res, npc;
    logic            br;
    control_s        ctrl;
    string           tag;
  } exp_t;
  logic clk = 1'b0, rst_n;
  int n_cmp = 0, n_bad = 0, k, nb, nr;
  exp_t sb[$];
  exp_t e;
  logic [XLEN-1:0] mn, rv;
  exec_unit_if #(.XLEN(XLEN)) bus ();
  exec_unit #(.XLEN(XLEN)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [XLEN-1:0] sx(input int v);
    return XLEN'(v);
  endfunction
  function automatic control_s mk(input int cls, input logic [2:0] f, input logic iop = 1'b0, input logic im = 1'b0);
    control_s cw = '0;
    cw.fcs_opcode = f;
    cw.iop = iop;
    cw.alu_imm = im;
    cw.alu = cls == C_ALU;
    cw.cond_branch = cls == C_BR;
    cw.uncond_branch = cls == C_JMP;
    cw.load_upper_imm = cls == C_LUI;
    cw.mem = cls == C_MEM;
    cw.muldiv = cls == C_MD;
    return cw;
  endfunction
  function automatic exp_t model(input control_s cw, input logic [XLEN-1:0] a, b, imm, pc, input string tag);
    exp_t x;
    logic [XLEN-1:0] p2, r, lo_min;
    logic [2*XLEN-1:0] sa, sb2, ua, ub, pp;
    int sh;
    x.ctrl = cw; x.tag = tag; x.br = 1'b0; x.npc = pc + XLEN'(4); r = '0;
    p2 = cw.alu_imm ? imm : b;
    sh = int'(p2 % XLEN);
    lo_min = XLEN'(1) << (XLEN - 1);
    if (cw.muldiv) begin
      sa = {{XLEN{a[XLEN-1]}}, a}; ua = {{XLEN{1'b0}}, a};
      sb2 = {{XLEN{b[XLEN-1]}}, b}; ub = {{XLEN{1'b0}}, b};
      case (cw.fcs_opcode)
        3'd0: begin pp = ua * ub; r = pp[XLEN-1:0]; end
        3'd1: begin pp = sa * sb2; r = pp[2*XLEN-1:XLEN]; end
        3'd2: begin pp = sa * ub; r = pp[2*XLEN-1:XLEN]; end
        3'd3: begin pp = ua * ub; r = pp[2*XLEN-1:XLEN]; end
        3'd4: if (b == '0) r = '1; else if (a == lo_min && b == '1) r = lo_min; else r = $signed(a) / $signed(b);
        3'd5: if (b == '0) r = '1; else r = a / b;
        3'd6: if (b == '0) r = a; else if (a == lo_min && b == '1) r = '0; else r = $signed(a) % $signed(b);
        default: if (b == '0) r = a; else r = a % b;
      endcase
    end else if (cw.cond_branch) begin
      case (cw.fcs_opcode)
        3'd0: x.br = a == b;
        3'd1: x.br = a != b;
        3'd4: x.br = $signed(a) < $signed(b);
        3'd5: x.br = $signed(a) >= $signed(b);
        3'd6: x.br = a < b;
        default: x.br = a >= b;
      endcase
      if (x.br) x.npc = pc + imm;
    end else if (cw.uncond_branch) begin
      r = pc + XLEN'(4);
      x.br = 1'b1;
      if (cw.fcs_opcode == 3'd3) begin x.npc = a + imm; x.npc[0] = 1'b0; end
      else x.npc = pc + imm;
    end else if (cw.load_upper_imm) r = cw.iop ? imm : pc + imm;
    else if (cw.mem) r = a + imm;
    else case (cw.fcs_opcode)
      3'd0: r = cw.iop ? a - p2 : a + p2;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(p2)) ? XLEN'(1) : XLEN'(0);
      3'd3: r = (a < p2) ? XLEN'(1) : XLEN'(0);
      3'd4: r = a ^ p2;
      3'd5: if (cw.iop) r = $signed(a) >>> sh; else r = a >> sh;
      3'd6: r = a | p2;
      default: r = a & p2;
    endcase
    x.res = r;
    return x;
  endfunction
  task automatic issue(input control_s cw, input logic [XLEN-1:0] a, b, imm, pc, input string tag);
    int w = 0;
    bus.i_valid = 1'b1; bus.i_control_signal = cw;
    bus.i_rs1 = a; bus.i_rs2 = b; bus.i_imm = imm; bus.i_pc = pc;
    do begin @(negedge clk); w++; end while (!bus.o_ready && w < 200);
    if (!bus.o_ready) check({tag, "_accept_timeout"}, 64'(bus.o_ready), 64'(1));
    else sb.push_back(model(cw, a, b, imm, pc, tag));
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask
  task automatic wait_drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 500) begin @(negedge clk); w++; end
    check({tag, "_drained"}, 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) check("unexpected_valid", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        check({e.tag, "_result"}, 64'(bus.o_result), 64'(e.res));
        check({e.tag, "_next_pc"}, 64'(bus.o_next_pc), 64'(e.npc));
        check({e.tag, "_branch"}, 64'(bus.o_branch), 64'(e.br));
        check({e.tag, "_ctrl"}, 64'(bus.o_control_signal), 64'(e.ctrl));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    mn = XLEN'(1) << (XLEN - 1);
    rv = XLEN'(rapid_pkg::RESET_VECTOR);
    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_control_signal = '0;
    bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_imm = '0; bus.i_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.o_valid), 64'(0));
    check("rst_ready", 64'(bus.o_ready), 64'(1));
    check("rst_next_pc", 64'(bus.o_next_pc), 64'(rv));
    check("rst_result", 64'(bus.o_result), 64'(0));
    check("rst_branch", 64'(bus.o_branch), 64'(0));
    check("rst_busy", 64'(bus.o_busy), 64'(0));
    check("rst_ctrl", 64'(bus.o_control_signal), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.o_ready), 64'(1));
    check("post_rst_valid", 64'(bus.o_valid), 64'(0));
    @(posedge clk); #1;
    issue(mk(C_ALU, ALU_ADD_SUB, 0, 1), 5, 0, sx(-7), 'h10, "addi");
    issue(mk(C_ALU, ALU_ADD_SUB, 1), 3, 10, 0, 'h14, "sub");
    issue(mk(C_ALU, ALU_SRL_SRA, 1, 1), mn, 0, 4, 'h18, "srai");
    issue(mk(C_ALU, ALU_SRL_SRA, 0), mn, 4, 0, 'h1c, "srl");
    issue(mk(C_ALU, ALU_SLL, 0), 1, XLEN'(XLEN + 3), 0, 'h20, "sll_mask");
    issue(mk(C_ALU, ALU_SLT, 0), sx(-1), 1, 0, 'h24, "slt");
    issue(mk(C_ALU, ALU_SLTU, 0), sx(-1), 1, 0, 'h28, "sltu");
    issue(mk(C_ALU, ALU_XOR, 0, 1), 'hf0f0, 0, 'h0ff0, 'h2c, "xori");
    issue(mk(C_ALU, ALU_OR, 0), 'h1200, 'h0034, 0, 'h30, "or");
    issue(mk(C_ALU, ALU_AND, 0), sx(-2), 'h7f, 0, 'h34, "and");
    issue(mk(C_BR, BR_LTU), 1, sx(-1), 'h20, 'h100, "bltu");
    issue(mk(C_BR, BR_EQ), 5, 6, 'h40, 'h104, "beq_nt");
    issue(mk(C_BR, BR_GE), sx(-3), 2, 'h40, 'h108, "bge_nt");
    issue(mk(C_BR, BR_GEU), sx(-1), 2, sx(-16), 'h10c, "bgeu");
    issue(mk(C_BR, BR_NE), 7, 8, 'h8, 'h110, "bne");
    issue(mk(C_JMP, JMP_JAL), 0, 0, sx(-8), 'h200, "jal");
    issue(mk(C_JMP, JMP_JALR), 'h1001, 0, 2, 'h40, "jalr");
    issue(mk(C_LUI, 3'b000, 1), 0, 0, 'h12345000, 'h44, "lui");
    issue(mk(C_LUI, 3'b000, 0), 0, 0, 'h2000, 'h1000, "auipc");
    issue(mk(C_MEM, 3'b010), 'h800, 0, sx(-4), 'h48, "mem");
    wait_drain("single");
    issue(mk(C_MD, MD_MULH), sx(-2), 3, 0, 'h50, "mulh");
    k = 0; nb = 0; nr = 0;
    while (k < 200) begin
      @(negedge clk);
      if (bus.o_valid) break;
      nb += int'(bus.o_busy);
      nr += int'(bus.o_ready);
      @(posedge clk);
      k++;
    end
    check("mulh_latency", 64'(k), 64'(XLEN + 1));
    check("mulh_busy_cycles", 64'(nb), 64'(XLEN));
    check("mulh_ready_low", 64'(nr), 64'(0));
    @(posedge clk); #1;
    issue(mk(C_MD, MD_MUL), sx(-5), 7, 0, 'h54, "mul");
    issue(mk(C_MD, MD_MULHSU), sx(-2), 3, 0, 'h58, "mulhsu");
    issue(mk(C_MD, MD_MULHU), sx(-1), sx(-1), 0, 'h5c, "mulhu");
    issue(mk(C_MD, MD_DIV), 7, 0, 0, 'h60, "div_by0");
    issue(mk(C_MD, MD_DIV), sx(-7), 2, 0, 'h64, "div_neg");
    issue(mk(C_MD, MD_DIV), mn, sx(-1), 0, 'h68, "div_ovf");
    issue(mk(C_MD, MD_REM), mn, sx(-1), 0, 'h6c, "rem_ovf");
    issue(mk(C_MD, MD_REM), sx(-7), 2, 0, 'h70, "rem_neg");
    issue(mk(C_MD, MD_DIVU), sx(-1), 3, 0, 'h74, "divu");
    issue(mk(C_MD, MD_REMU), 7, 0, 0, 'h78, "remu_by0");
    wait_drain("muldiv");
    bus.i_ready = 1'b0;
    fork
      begin
        issue(mk(C_ALU, ALU_ADD_SUB), 0, 1, 0, 'h80, "stall_a");
        issue(mk(C_ALU, ALU_ADD_SUB), 1, 1, 0, 'h84, "stall_b");
        issue(mk(C_ALU, ALU_ADD_SUB), 2, 1, 0, 'h88, "stall_c");
      end
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.o_valid && k < 50);
        check("stall_hold0", 64'(bus.o_result), 64'(1));
        @(negedge clk);
        check("stall_hold1", 64'(bus.o_result), 64'(1));
        check("stall_valid_held", 64'(bus.o_valid), 64'(1));
        check("stall_ready_low", 64'(bus.o_ready), 64'(0));
        @(posedge clk); #1 bus.i_ready = 1'b1;
      end
    join
    wait_drain("stall");
    issue(mk(C_MD, MD_DIV), 100, 7, 0, 'h300, "div_rst");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_div_valid", 64'(bus.o_valid), 64'(0));
    check("rst_mid_div_busy", 64'(bus.o_busy), 64'(0));
    check("rst_mid_div_ready", 64'(bus.o_ready), 64'(1));
    check("rst_mid_div_next_pc", 64'(bus.o_next_pc), 64'(rv));
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_valid", 64'(bus.o_valid), 64'(0));
    check("rst_release_ready", 64'(bus.o_ready), 64'(1));
    @(posedge clk); #1;
    issue(mk(C_ALU, ALU_ADD_SUB, 0, 1), 40, 0, 2, 'h304, "after_rst");
    wait_drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
